// File: rtl/load_unit_ctrl.sv
// Multi-cycle RV64 load sequencer: aligned doubleword read, byte-align, extend, one-cycle write-back.
// Optional misaligned-access trap enabled by LOAD_MISALIGN_TRAP_EN; done follows accept by MEM_LATENCY+3 cycles.
module load_unit_ctrl #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic [63:0] mem_addr,
  output logic        mem_rd,
  input  logic [63:0] mem_rdata,
  output logic [63:0] ext_data,
  output logic [2:0]  ext_sel,
  input  logic [63:0] ext_result,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        done,
  output logic        illegal,
  output logic        misaligned
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, EXT, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  f3_q;
  logic [2:0]  off_q;
  logic [4:0]  rd_q;
  logic [63:0] mem_addr_q;
  logic [3:0]  cnt_q;
  logic [63:0] ext_data_q;
  logic [2:0]  ext_sel_q;
  logic [63:0] wb_data_q;
  logic [4:0]  wb_rd_q;
  logic        illegal_q;
  logic        mis_q;

  logic        cmd_illegal;
  logic        cmd_mis;
  logic        accept;

  function automatic logic [2:0] sel_code(input logic [2:0] f3);
    case (f3)
      3'b000:  sel_code = 3'd3;
      3'b001:  sel_code = 3'd2;
      3'b010:  sel_code = 3'd1;
      3'b011:  sel_code = 3'd0;
      3'b100:  sel_code = 3'd6;
      3'b101:  sel_code = 3'd5;
      3'b110:  sel_code = 3'd4;
      default: sel_code = 3'd0;
    endcase
  endfunction

`ifdef LOAD_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
    case (f3)
      3'b001, 3'b101: is_misaligned = off[0];
      3'b010, 3'b110: is_misaligned = |off[1:0];
      3'b011:         is_misaligned = |off;
      default:        is_misaligned = 1'b0;
    endcase
  endfunction
  assign cmd_mis = is_misaligned(funct3, addr[2:0]);
`else
  assign cmd_mis = 1'b0;
`endif

  assign cmd_illegal = (funct3 == 3'b111);
  assign accept      = (state_q == IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (cmd_illegal || cmd_mis) ? DONE : REQ;
      REQ:  state_d = WAIT;
      WAIT: if (cnt_q == 4'd0) state_d = EXT;
      EXT:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    mem_rd     = (state_q == REQ);
    done       = (state_q == DONE);
    illegal    = (state_q == DONE) && illegal_q;
    misaligned = (state_q == DONE) && mis_q;
    wb_en      = (state_q == DONE) && !illegal_q && !mis_q && (rd_q != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f3_q       <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
      ext_data_q <= '0;
      ext_sel_q  <= '0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      illegal_q  <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      if (accept) begin
        f3_q      <= funct3;
        off_q     <= addr[2:0];
        rd_q      <= rd_in;
        illegal_q <= cmd_illegal;
        mis_q     <= cmd_mis;
        // Trapped commands skip EXT, so their write-back register is captured here.
        if (cmd_illegal || cmd_mis) wb_rd_q <= rd_in;
        else                        mem_addr_q <= {addr[63:3], 3'b000};
      end
      if (state_q == REQ)
        cnt_q <= 4'(MEM_LATENCY - 1);
      else if (state_q == WAIT && cnt_q != 4'd0)
        cnt_q <= cnt_q - 4'd1;
      // Upper bytes beyond the doubleword are zero-filled by the logical shift.
      if (state_q == WAIT && cnt_q == 4'd0) begin
        ext_data_q <= mem_rdata >> {off_q, 3'b000};
        ext_sel_q  <= sel_code(f3_q);
      end
      if (state_q == EXT) begin
        wb_data_q <= ext_result;
        wb_rd_q   <= rd_q;
      end
    end
  end

  assign mem_addr = mem_addr_q;
  assign ext_data = ext_data_q;
  assign ext_sel  = ext_sel_q;
  assign wb_data  = wb_data_q;
  assign wb_rd    = wb_rd_q;

endmodule

// File: tb/tb_load_unit_ctrl.sv
// Directed bench for load_unit_ctrl with a behavioural sign/zero-extension unit.
module tb_load_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [63:0] addr = '0;
  logic [4:0]  rd_in = '0;
  logic [63:0] mem_rdata = '0;
  logic        busy, mem_rd, wb_en, done, illegal, misaligned;
  logic [63:0] mem_addr, ext_data, ext_result, wb_data;
  logic [2:0]  ext_sel;
  logic [4:0]  wb_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_unit_ctrl #(.MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .addr(addr),
    .rd_in(rd_in), .busy(busy), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .ext_data(ext_data), .ext_sel(ext_sel),
    .ext_result(ext_result), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .done(done), .illegal(illegal), .misaligned(misaligned)
  );

  // Extension unit: LD=0 LW=1 LH=2 LB=3 LWU=4 LHU=5 LBU=6
  always_comb begin
    ext_result = ext_data;
    case (ext_sel)
      3'd1: ext_result = {{32{ext_data[31]}}, ext_data[31:0]};
      3'd2: ext_result = {{48{ext_data[15]}}, ext_data[15:0]};
      3'd3: ext_result = {{56{ext_data[7]}},  ext_data[7:0]};
      3'd4: ext_result = {32'd0, ext_data[31:0]};
      3'd5: ext_result = {48'd0, ext_data[15:0]};
      3'd6: ext_result = {56'd0, ext_data[7:0]};
      default: ext_result = ext_data;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge while the DUT is IDLE; returns at the first IDLE negedge after done.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [63:0] a,
                          input logic [4:0] rd, input logic [63:0] rdata,
                          input int exp_lat, input int exp_rd_cnt,
                          input logic [63:0] exp_ext, input logic [2:0] exp_sel,
                          input logic [63:0] exp_wb, input logic exp_wben,
                          input logic exp_ill, input logic exp_mis);
    int lat;
    int rd_cnt;
    logic [63:0] seen_addr;
    logic got_done;
    funct3 = f3; addr = a; rd_in = rd; mem_rdata = rdata; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; rd_cnt = 0; seen_addr = '0; got_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_rd) begin
        rd_cnt++;
        seen_addr = mem_addr;
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
      lat++;
      @(negedge clk);
    end
    check({tag, "_done"}, 64'(got_done), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_mem_rd_pulses"}, 64'(rd_cnt), 64'(exp_rd_cnt));
    if (exp_rd_cnt > 0) begin
      check({tag, "_mem_addr"}, seen_addr, {a[63:3], 3'b000});
      check({tag, "_ext_data"}, ext_data, exp_ext);
      check({tag, "_ext_sel"}, 64'(ext_sel), 64'(exp_sel));
      check({tag, "_wb_data"}, wb_data, exp_wb);
    end
    check({tag, "_wb_en"}, 64'(wb_en), 64'(exp_wben));
    check({tag, "_wb_rd"}, 64'(wb_rd), 64'(rd));
    check({tag, "_illegal"}, 64'(illegal), 64'(exp_ill));
    check({tag, "_misaligned"}, 64'(misaligned), 64'(exp_mis));
    @(negedge clk);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_done_after"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat;
    int rd_cnt;
    int busy_lo;
    int stray;
    logic [63:0] seen_addr;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_outs", {59'd0, mem_rd, wb_en, done, illegal, misaligned}, 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_load("ld",  3'b011, 64'h1000, 5'd5, 64'h8877665544332211, 4, 1,
             64'h8877665544332211, 3'd0, 64'h8877665544332211, 1'b1, 1'b0, 1'b0);
    run_load("lb",  3'b000, 64'h1003, 5'd6, 64'h00000000F0000000, 4, 1,
             64'hF0, 3'd3, 64'hFFFFFFFFFFFFFFF0, 1'b1, 1'b0, 1'b0);
    run_load("lbu", 3'b100, 64'h1003, 5'd6, 64'h00000000F0000000, 4, 1,
             64'hF0, 3'd6, 64'h00000000000000F0, 1'b1, 1'b0, 1'b0);
    run_load("lw",  3'b010, 64'h2004, 5'd10, 64'h8000000112345678, 4, 1,
             64'h80000001, 3'd1, 64'hFFFFFFFF80000001, 1'b1, 1'b0, 1'b0);
    run_load("lwu", 3'b110, 64'h2004, 5'd10, 64'h8000000112345678, 4, 1,
             64'h80000001, 3'd4, 64'h0000000080000001, 1'b1, 1'b0, 1'b0);
    run_load("ill", 3'b111, 64'h2000, 5'd11, 64'h0, 1, 0,
             64'h0, 3'd0, 64'h0, 1'b0, 1'b1, 1'b0);
    run_load("ld_x0", 3'b011, 64'h1008, 5'd0, 64'h55, 4, 1,
             64'h55, 3'd0, 64'h55, 1'b0, 1'b0, 1'b0);
`ifdef LOAD_MISALIGN_TRAP_EN
    run_load("lh_mis", 3'b001, 64'h11, 5'd12, 64'h0000000000ABCD00, 1, 0,
             64'h0, 3'd0, 64'h0, 1'b0, 1'b0, 1'b1);
    run_load("lw_cross", 3'b010, 64'h7006, 5'd13, 64'hAABBCCDD00000000, 1, 0,
             64'h0, 3'd0, 64'h0, 1'b0, 1'b0, 1'b1);
`else
    run_load("lh_odd", 3'b001, 64'h11, 5'd12, 64'h0000000000ABCD00, 4, 1,
             64'hABCD, 3'd2, 64'hFFFFFFFFFFFFABCD, 1'b1, 1'b0, 1'b0);
    run_load("lw_cross", 3'b010, 64'h7006, 5'd13, 64'hAABBCCDD00000000, 4, 1,
             64'hAABB, 3'd1, 64'h000000000000AABB, 1'b1, 1'b0, 1'b0);
`endif

    // start held high through a whole LD: only the first command may take effect
    funct3 = 3'b011; addr = 64'h3000; rd_in = 5'd7; mem_rdata = 64'hCAFE; start = 1'b1;
    @(negedge clk);
    addr = 64'h4000; rd_in = 5'd9; funct3 = 3'b111;
    lat = 1; rd_cnt = 0; busy_lo = 0; seen_addr = '0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) busy_lo++;
      if (mem_rd) begin
        rd_cnt++;
        seen_addr = mem_addr;
      end
      if (done) break;
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    check("hold_latency", 64'(lat), 64'd4);
    check("hold_mem_rd_pulses", 64'(rd_cnt), 64'd1);
    check("hold_mem_addr", seen_addr, 64'h3000);
    check("hold_busy_low", 64'(busy_lo), 64'd0);
    check("hold_wb_rd", 64'(wb_rd), 64'd7);
    check("hold_wb_data", wb_data, 64'hCAFE);
    check("hold_wb_en", 64'(wb_en), 64'd1);
    @(negedge clk);
    check("hold_busy_after", 64'(busy), 64'd0);

    // reset while the read is outstanding
    funct3 = 3'b011; addr = 64'h5000; rd_in = 5'd3; mem_rdata = 64'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rstw_in_wait", 64'(busy), 64'd1);
    reset = 1'b1;
    mem_rdata = 64'hDEADBEEFDEADBEEF;
    @(negedge clk);
    reset = 1'b0;
    check("rstw_busy", 64'(busy), 64'd0);
    check("rstw_mem_addr", mem_addr, 64'd0);
    check("rstw_ext_data", ext_data, 64'd0);
    check("rstw_wb_data", wb_data, 64'd0);
    check("rstw_ctl", {54'd0, ext_sel, wb_rd, mem_rd, wb_en}, 64'd0);
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || mem_rd || busy) stray++;
    end
    check("rstw_no_activity", 64'(stray), 64'd0);
    run_load("ld_fresh", 3'b011, 64'h6000, 5'd4, 64'h0123456789ABCDEF, 4, 1,
             64'h0123456789ABCDEF, 3'd0, 64'h0123456789ABCDEF, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
